// File: rtl/div_step_seq.sv
// div_step_seq
// Iteration sequencer for the compensated divider. Holds the partial remainder
// and divisor in registers, presents them to the external combinational
// compensated-subtract stage, and folds the stage result back into the
// remainder while shifting one quotient bit per clock (restoring style).
// A start/busy/done handshake frames each operation; flush aborts it.
module div_step_seq #(
  parameter int ITER = 8,   // quotient bits per operation, 2..16
  parameter int W    = 4    // remainder/divisor code width (subtract stage is 4-bit)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [W-1:0]    a_in,
  input  logic [W-1:0]    b_in,
  output logic [W-1:0]    sub_x,
  output logic [W-1:0]    sub_y,
  input  logic [W-1:0]    sub_z,
  output logic            busy,
  output logic            done,
  output logic [ITER-1:0] q,
  output logic [W-1:0]    rem
);

  // Iteration counter only has to reach ITER-1; it never wraps mid-operation.
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [W-1:0]    rem_q,   rem_d;
  logic [W-1:0]    b_q,     b_d;
  logic [ITER-1:0] q_q,     q_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;

  // Quotient bit for the current iteration: can the divisor be taken out?
  logic q_bit;

  // Next-state, datapath and handshake decode for one iteration per clock.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    b_d     = b_q;
    q_d     = q_q;
    q_bit   = (rem_q >= b_q);

    case (state_q)
      S_IDLE: begin
        // flush beats start; the previous result stays on q/rem until a new
        // operation is actually accepted.
        if (start && !flush) begin
          rem_d   = a_in;
          b_d     = b_in;
          q_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          // Abort: partial q/rem are frozen where they are.
          state_d = S_IDLE;
        end else begin
          q_d   = {q_q[ITER-2:0], q_bit};
          // The subtract stage result is consumed in the same cycle; on a
          // zero bit the remainder just doubles and its MSB is lost.
          rem_d = q_bit ? sub_z : {rem_q[W-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // start here is deliberately dropped, never queued.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy follows the state register; done is the registered echo of the
    // DONE state, suppressed when that final cycle is flushed.
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE) && !flush;
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      b_q     <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      b_q     <= b_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sub_x = rem_q;
  assign sub_y = b_q;
  assign q     = q_q;
  assign rem   = rem_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_div_step_seq.sv
// tb_div_step_seq
// Randomised plus directed stimulus for div_step_seq (ITER=4). A driver issues
// start/flush and pushes expected results into a scoreboard queue; a separate
// monitor pops and compares whenever done is seen.
module tb_div_step_seq;
  localparam int ITER = 4;
  localparam int W    = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [W-1:0]    a_in = '0;
  logic [W-1:0]    b_in = '0;
  logic [W-1:0]    sub_x, sub_y, sub_z;
  logic            busy, done;
  logic [ITER-1:0] q;
  logic [W-1:0]    rem;

  always #5 clk = ~clk;

  div_step_seq #(.ITER(ITER), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .a_in(a_in), .b_in(b_in), .sub_x(sub_x), .sub_y(sub_y), .sub_z(sub_z),
    .busy(busy), .done(done), .q(q), .rem(rem)
  );

  // Behavioural stand-in for the compensated-subtract stage: anchored on the
  // characterised operand points, plain modulo-16 difference elsewhere.
  function automatic logic [3:0] stage(input logic [3:0] x, input logic [3:0] y);
    case ({x, y})
      8'h90:   return 4'd2;
      8'h20:   return 4'd14;
      8'hE0:   return 4'd10;
      8'hA0:   return 4'd3;
      8'h85:   return 4'd9;
      8'h95:   return 4'd6;
      default: return x - y;
    endcase
  endfunction

  always_comb sub_z = stage(sub_x, sub_y);

  typedef struct {
    int q;
    int rem;
    int done_edge;
  } exp_t;

  // Reference divider: long division on integers using the stage model.
  function automatic exp_t ref_div(input int a, input int b);
    exp_t r;
    int   rv;
    int   qv;
    rv = a;
    qv = 0;
    for (int i = 0; i < ITER; i++) begin
      if (rv >= b) begin
        qv = qv * 2 + 1;
        rv = int'(stage(4'(rv), 4'(b)));
      end else begin
        qv = qv * 2;
        rv = (rv * 2) % 16;
      end
    end
    r.q = qv;
    r.rem = rv;
    r.done_edge = 0;
    return r;
  endfunction

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_count = 0;
  exp_t sbq[$];

  // Driver-side picture of the DUT timeline, in clock-edge numbers.
  int   acc_edge = -1;
  int   run_end = -1;
  exp_t pend;
  bit   pend_valid = 1'b0;
  int   held_q = 0;
  int   held_rem = 0;
  bit   held_valid = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, expv, cyc);
    end
  endtask

  // One clock of stimulus, entered and left at a falling edge.
  task automatic step(input bit st, input bit fl, input int a, input int b);
    int   e;
    exp_t ev;
    check("busy", int'(busy), int'(cyc >= acc_edge && cyc < run_end));
    if (cyc >= run_end && pend_valid) begin
      held_q = pend.q;
      held_rem = pend.rem;
      held_valid = 1'b1;
      pend_valid = 1'b0;
    end
    if (cyc >= run_end && held_valid) begin
      check("held_q", int'(q), held_q);
      check("held_rem", int'(rem), held_rem);
    end
    start = st;
    flush = fl;
    a_in = 4'(a);
    b_in = 4'(b);
    e = cyc + 1;
    if (e <= run_end) begin
      if (fl) begin
        run_end = e;
        void'(sbq.pop_back());
        pend_valid = 1'b0;
        held_valid = 1'b0;
      end
    end else if (st && !fl) begin
      ev = ref_div(a, b);
      ev.done_edge = e + ITER + 1;
      sbq.push_back(ev);
      pend = ev;
      pend_valid = 1'b1;
      acc_edge = e;
      run_end = e + ITER + 1;
    end
    @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sbq.size() == 0) begin
          check("spurious_done", int'(done), 0);
        end else begin
          exp_t ev;
          ev = sbq.pop_front();
          done_count++;
          check("q", int'(q), ev.q);
          check("rem", int'(rem), ev.rem);
          check("done_edge", cyc, ev.done_edge);
          $display("op %0d: q=%0d rem=%0d at edge %0d", done_count, q, rem, cyc);
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].done_edge) begin
        check("done_timeout", cyc, sbq[0].done_edge);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[5];
    int dc0;
    seq = '{9, 2, 14, 10, 3};

    // Power-on reset values.
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(q), 0);
    check("rst_rem", int'(rem), 0);
    check("rst_sub_x", int'(sub_x), 0);
    check("rst_sub_y", int'(sub_y), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2 / 5: bits 0,0,1,1, remainder 6, done 5 edges after accept.
    step(1, 0, 2, 5);
    repeat (ITER + 2) step(0, 0, 0, 0);

    // 9 / 0: every bit set, remainder walks 9,2,14,10,3.
    step(1, 0, 9, 0);
    for (int k = 0; k <= ITER; k++) begin
      check("rem_seq", int'(sub_x), seq[k]);
      step(0, 0, 0, 0);
    end
    repeat (2) step(0, 0, 0, 0);

    // start held high: one accept per ITER+2 cycles, nothing queued.
    dc0 = done_count;
    repeat (3 * (ITER + 2)) step(1, 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    repeat (ITER + 3) step(0, 0, 0, 0);
    check("held_start_dones", done_count - dc0, 3);

    // flush on the second RUN cycle, then a normal operation.
    step(1, 0, 9, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 2, 5);
    repeat (ITER + 3) step(0, 0, 0, 0);

    // Back-to-back: second start in the cycle after done.
    step(1, 0, 9, 0);
    repeat (ITER + 1) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 2, 5);
    repeat (ITER + 3) step(0, 0, 0, 0);

    // Asynchronous reset in the middle of RUN.
    step(1, 0, 9, 0);
    step(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_q", int'(q), 0);
    check("mid_rst_rem", int'(rem), 0);
    sbq.delete();
    acc_edge = -1;
    run_end = -1;
    pend_valid = 1'b0;
    held_q = 0;
    held_rem = 0;
    held_valid = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (ITER + 3) step(0, 0, 0, 0);

    // Random traffic with occasional flushes.
    repeat (400) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    repeat (ITER + 4) step(0, 0, 0, 0);
    check("queue_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
